// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// default memory depth and the instruction word width.
package imem_loader_pkg;

    localparam int MEM_NUM_DEFAULT = 4096;
    localparam int DATA_WIDTH      = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit words, writes them to the
// instruction memory and holds the core in reset until the image is loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_NUM = MEM_NUM_DEFAULT,
    parameter int ADDR_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_W:0]       words_loaded
);

    if ((64'd1 << ADDR_W) < 64'(MEM_NUM)) begin : g_addr_w_check
        $error("imem_loader: ADDR_W too narrow for MEM_NUM");
    end

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_NUM - 1);

    state_e                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d;
    logic [ADDR_W:0]         words_q, words_d;
    logic                    ovf_q, ovf_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    // fin_q: the word in flight is the final one; ovfp_q: it ends by overflow
    logic                    fin_q, fin_d;
    logic                    ovfp_q, ovfp_d;

    logic                    xfer;
    logic [ADDR_W-1:0]       addr_cur;
    logic [DATA_WIDTH-1:0]   word_next;

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        buf_d     = buf_q;
        words_d   = words_q;
        ovf_d     = ovf_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        fin_d     = fin_q;
        ovfp_d    = ovfp_q;

        byte_ready = (state_q == ST_LOAD) && !fin_q;
        xfer       = byte_valid && byte_ready;
        // A byte may arrive during a write cycle, before the address has advanced
        addr_cur   = we_q ? addr_q + 1'b1 : addr_q;
        word_next  = buf_q | (DATA_WIDTH'(byte_data) << {lane_q, 3'b000});

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    lane_d  = 2'd0;
                    addr_d  = '0;
                    buf_d   = '0;
                    words_d = '0;
                    ovf_d   = 1'b0;
                    fin_d   = 1'b0;
                    ovfp_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (we_q) begin
                    addr_d  = addr_q + 1'b1;
                    words_d = words_q + 1'b1;
                    if (fin_q) begin
                        state_d = ST_DONE;
                        ovf_d   = ovfp_q;
                        fin_d   = 1'b0;
                    end
                end
                if (xfer) begin
                    if (lane_q == 2'd3 || byte_last) begin
                        we_d    = 1'b1;
                        wdata_d = word_next;
                        waddr_d = addr_cur;
                        buf_d   = '0;
                        lane_d  = 2'd0;
                        fin_d   = byte_last || (addr_cur == LAST_ADDR);
                        ovfp_d  = !byte_last;
                    end else begin
                        buf_d  = word_next;
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            lane_q  <= 2'd0;
            addr_q  <= '0;
            buf_q   <= '0;
            words_q <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            fin_q   <= 1'b0;
            ovfp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            fin_q   <= fin_d;
            ovfp_q  <= ovfp_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign core_hold    = (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign overflow     = ovf_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (default depth and a 4-word
// memory) share the byte source; writes are compared to a byte-to-word model.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic byte_last = 1'b0;

    logic        rdy_b, we_b, hold_b, done_b, ovf_b;
    logic [11:0] waddr_b;
    logic [31:0] wdata_b;
    logic [12:0] words_b;

    logic        rdy_s, we_s, hold_s, done_s, ovf_s;
    logic [1:0]  waddr_s;
    logic [31:0] wdata_s;
    logic [2:0]  words_s;

    always #5 clk = ~clk;

    imem_loader u_big (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(rdy_b),
        .mem_we(we_b), .mem_waddr(waddr_b), .mem_wdata(wdata_b),
        .core_hold(hold_b), .done(done_b), .overflow(ovf_b), .words_loaded(words_b)
    );

    imem_loader #(.MEM_NUM(4), .ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(rdy_s),
        .mem_we(we_s), .mem_waddr(waddr_s), .mem_wdata(wdata_s),
        .core_hold(hold_s), .done(done_s), .overflow(ovf_s), .words_loaded(words_s)
    );

    // sel chooses which instance the driver handshakes with and the monitor records
    bit          sel = 1'b0;
    logic        c_rdy, c_we, c_hold, c_done, c_ovf;
    int          c_waddr, c_words;
    logic [31:0] c_wdata;
    assign c_rdy   = sel ? rdy_s  : rdy_b;
    assign c_we    = sel ? we_s   : we_b;
    assign c_hold  = sel ? hold_s : hold_b;
    assign c_done  = sel ? done_s : done_b;
    assign c_ovf   = sel ? ovf_s  : ovf_b;
    assign c_waddr = sel ? int'(waddr_s) : int'(waddr_b);
    assign c_wdata = sel ? wdata_s : wdata_b;
    assign c_words = sel ? int'(words_s) : int'(words_b);

    int          n_chk = 0;
    int          n_fail = 0;
    int          hold_bad = 0;
    int          wa[$];
    logic [31:0] wd[$];
    logic [7:0]  tx_q[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (c_we === 1'b1) begin
            wa.push_back(c_waddr);
            wd.push_back(c_wdata);
        end
    end

    // Reference: group bytes four at a time little-endian, zero-pad, cap at limit words
    function automatic void build_exp(input int nbytes, input int limit);
        int nw;
        exp_q.delete();
        nw = (nbytes + 3) / 4;
        if (nw > limit) nw = limit;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] word;
            word = 32'h0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < nbytes) word[8*k +: 8] = tx_q[4 * w + k];
            exp_q.push_back(word);
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wa.delete(); wd.delete();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_bytes(input bit with_last, input int gap_pct, input int first,
                              input int cnt, input int max_cyc, output int accepted);
        int idx, cyc;
        idx = first; cyc = 0;
        while (idx < first + cnt && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (c_done !== 1'b1 && c_hold !== 1'b1) hold_bad++;
            byte_valid = ($urandom_range(99) >= gap_pct);
            byte_data  = tx_q[idx];
            byte_last  = with_last && (idx == tx_q.size() - 1);
            if (byte_valid && c_rdy === 1'b1) idx++;
        end
        @(negedge clk);
        byte_valid = 1'b0; byte_last = 1'b0;
        accepted = idx - first;
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (rdy_b !== 1'b0) begin n_fail++; $display("FAIL reset byte_ready: got %0b want 0", rdy_b); end
        n_chk++; if (we_b !== 1'b0) begin n_fail++; $display("FAIL reset mem_we: got %0b want 0", we_b); end
        n_chk++; if (waddr_b !== 12'h0) begin n_fail++; $display("FAIL reset mem_waddr: got %0h want 0", waddr_b); end
        n_chk++; if (wdata_b !== 32'h0) begin n_fail++; $display("FAIL reset mem_wdata: got %0h want 0", wdata_b); end
        n_chk++; if (hold_b !== 1'b1) begin n_fail++; $display("FAIL reset core_hold: got %0b want 1", hold_b); end
        n_chk++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL reset done: got %0b want 0", done_b); end
        n_chk++; if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL reset overflow: got %0b want 0", ovf_b); end
        n_chk++; if (words_b !== 13'h0) begin n_fail++; $display("FAIL reset words_loaded: got %0d want 0", words_b); end
        apply_reset();
        repeat (2) @(negedge clk);
        n_chk++; if (rdy_b !== 1'b0) begin n_fail++; $display("FAIL idle byte_ready: got %0b want 0", rdy_b); end
    endtask

    task automatic test_two_words();
        int acc;
        sel = 1'b0;
        apply_reset();
        tx_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_start();
        send_bytes(1'b1, 0, 0, 8, 50, acc);
        repeat (4) @(negedge clk);
        n_chk++; if (wa.size() != 2) begin n_fail++; $display("FAIL two_words count: got %0d want 2", wa.size()); end
        else begin
            n_chk++; if (wa[0] != 0 || wd[0] !== 32'h00000013) begin n_fail++; $display("FAIL two_words w0: got %0d/%08h want 0/00000013", wa[0], wd[0]); end
            n_chk++; if (wa[1] != 1 || wd[1] !== 32'h00100093) begin n_fail++; $display("FAIL two_words w1: got %0d/%08h want 1/00100093", wa[1], wd[1]); end
        end
        n_chk++; if (c_done !== 1'b1) begin n_fail++; $display("FAIL two_words done: got %0b want 1", c_done); end
        n_chk++; if (c_hold !== 1'b0) begin n_fail++; $display("FAIL two_words core_hold: got %0b want 0", c_hold); end
        n_chk++; if (c_words != 2) begin n_fail++; $display("FAIL two_words words_loaded: got %0d want 2", c_words); end
        n_chk++; if (c_ovf !== 1'b0) begin n_fail++; $display("FAIL two_words overflow: got %0b want 0", c_ovf); end
    endtask

    // Restarts straight from DONE, no reset in between
    task automatic test_partial_restart();
        int acc;
        wa.delete(); wd.delete();
        tx_q = '{8'hAA, 8'hBB};
        do_start();
        n_chk++; if (c_done !== 1'b0 || c_words != 0) begin n_fail++; $display("FAIL restart clear: got done=%0b words=%0d want 0/0", c_done, c_words); end
        send_bytes(1'b1, 0, 0, 2, 50, acc);
        repeat (4) @(negedge clk);
        n_chk++; if (wa.size() != 1) begin n_fail++; $display("FAIL partial count: got %0d want 1", wa.size()); end
        else begin
            n_chk++; if (wa[0] != 0 || wd[0] !== 32'h0000BBAA) begin n_fail++; $display("FAIL partial w0: got %0d/%08h want 0/0000bbaa", wa[0], wd[0]); end
        end
        n_chk++; if (c_done !== 1'b1 || c_words != 1) begin n_fail++; $display("FAIL partial done: got done=%0b words=%0d want 1/1", c_done, c_words); end
    endtask

    task automatic test_overflow();
        int acc;
        sel = 1'b1;
        apply_reset();
        tx_q.delete();
        for (int i = 0; i < 20; i++) tx_q.push_back(8'($urandom));
        build_exp(20, 4);
        do_start();
        send_bytes(1'b0, 20, 0, 20, 80, acc);
        repeat (3) @(negedge clk);
        n_chk++; if (acc != 16) begin n_fail++; $display("FAIL overflow accepted: got %0d want 16", acc); end
        n_chk++; if (c_rdy !== 1'b0) begin n_fail++; $display("FAIL overflow byte_ready: got %0b want 0", c_rdy); end
        n_chk++; if (c_ovf !== 1'b1 || c_done !== 1'b1) begin n_fail++; $display("FAIL overflow flags: got ovf=%0b done=%0b want 1/1", c_ovf, c_done); end
        n_chk++; if (c_words != 4) begin n_fail++; $display("FAIL overflow words_loaded: got %0d want 4", c_words); end
        n_chk++; if (wa.size() != exp_q.size()) begin n_fail++; $display("FAIL overflow count: got %0d want %0d", wa.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wa.size(); i++) begin
            n_chk++;
            if (wa[i] != i || wd[i] !== exp_q[i]) begin n_fail++; $display("FAIL overflow w%0d: got %0d/%08h want %0d/%08h", i, wa[i], wd[i], i, exp_q[i]); end
        end
        sel = 1'b0;
    endtask

    task automatic test_random_gaps();
        int acc, len;
        sel = 1'b0;
        for (int t = 0; t < 4; t++) begin
            apply_reset();
            len = (t == 0) ? 64 : int'($urandom_range(1, 40));
            tx_q.delete();
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
            build_exp(len, 4096);
            hold_bad = 0;
            do_start();
            send_bytes(1'b1, 40, 0, len, 2000, acc);
            repeat (4) @(negedge clk);
            n_chk++; if (hold_bad != 0) begin n_fail++; $display("FAIL random core_hold dropped early: got %0d cycles want 0", hold_bad); end
            n_chk++; if (c_done !== 1'b1 || c_words != exp_q.size()) begin n_fail++; $display("FAIL random done/words: got %0b/%0d want 1/%0d", c_done, c_words, exp_q.size()); end
            n_chk++; if (wa.size() != exp_q.size()) begin n_fail++; $display("FAIL random count len=%0d: got %0d want %0d", len, wa.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < wa.size(); i++) begin
                n_chk++;
                if (wa[i] != i || wd[i] !== exp_q[i]) begin n_fail++; $display("FAIL random w%0d: got %0d/%08h want %0d/%08h", i, wa[i], wd[i], i, exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int acc;
        sel = 1'b0;
        apply_reset();
        tx_q.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
        do_start();
        send_bytes(1'b0, 0, 0, 6, 50, acc);
        #2 rst = 1'b0;
        #1;
        n_chk++; if (we_b !== 1'b0 || waddr_b !== 12'h0 || wdata_b !== 32'h0) begin n_fail++; $display("FAIL midreset write port: got we=%0b a=%0h d=%08h want 0/0/0", we_b, waddr_b, wdata_b); end
        n_chk++; if (rdy_b !== 1'b0 || hold_b !== 1'b1 || done_b !== 1'b0 || ovf_b !== 1'b0 || words_b !== 13'h0) begin n_fail++; $display("FAIL midreset status: got rdy=%0b hold=%0b done=%0b ovf=%0b words=%0d want 0/1/0/0/0", rdy_b, hold_b, done_b, ovf_b, words_b); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (wa.size() != 1) begin n_fail++; $display("FAIL midreset writes: got %0d want 1", wa.size()); end
        wa.delete(); wd.delete();
        build_exp(8, 4096);
        do_start();
        send_bytes(1'b1, 25, 0, 8, 200, acc);
        repeat (4) @(negedge clk);
        n_chk++; if (wa.size() != 2) begin n_fail++; $display("FAIL reload count: got %0d want 2", wa.size()); end
        for (int i = 0; i < 2 && i < wa.size(); i++) begin
            n_chk++;
            if (wa[i] != i || wd[i] !== exp_q[i]) begin n_fail++; $display("FAIL reload w%0d: got %0d/%08h want %0d/%08h", i, wa[i], wd[i], i, exp_q[i]); end
        end
    endtask

    task automatic test_start_mid_load();
        int acc;
        sel = 1'b0;
        apply_reset();
        tx_q.delete();
        for (int i = 0; i < 14; i++) tx_q.push_back(8'($urandom));
        build_exp(14, 4096);
        do_start();
        send_bytes(1'b0, 0, 0, 5, 50, acc);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_bytes(1'b1, 30, 5, 9, 300, acc);
        repeat (4) @(negedge clk);
        n_chk++; if (wa.size() != 4 || c_words != 4) begin n_fail++; $display("FAIL midstart count: got %0d/%0d want 4/4", wa.size(), c_words); end
        for (int i = 0; i < exp_q.size() && i < wa.size(); i++) begin
            n_chk++;
            if (wa[i] != i || wd[i] !== exp_q[i]) begin n_fail++; $display("FAIL midstart w%0d: got %0d/%08h want %0d/%08h", i, wa[i], wd[i], i, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_partial_restart();
        test_overflow();
        test_random_gaps();
        test_reset_mid_load();
        test_start_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
